// File: rtl/pipelined_control_unit.sv
// ---------------------------------------------------------------------------
// pipelined_control_unit
// Control path for a 5-stage MIPS pipeline. Decodes the ID-stage instruction
// and carries its control bundle through the ID/EX, EX/MEM and MEM/WB control
// registers. It also detects load-use hazards, resolves branches in EX, and
// drives stall, bubble and flush controls. A saturating counter records the
// cycles lost to stalls and taken branches.
//
// Ports
//   clk, rst                 rising-edge clock, async active-high reset
//   id_valid/opcode/funct/rs/rt   ID-stage instruction fields
//   ex_zero                  ALU zero flag of the instruction in EX
//   ex_*                     ID/EX control (registered)
//   mem_read, mem_write      EX/MEM control (registered)
//   wb_mem_to_reg, wb_reg_write   MEM/WB control (registered)
//   id_jump, id_jr           current ID instruction is j / jr (combinational)
//   branch_taken             branch in EX is taken (combinational)
//   pc_write, if_id_write    0 holds PC / IF-ID (combinational)
//   if_id_flush              zero IF/ID at the next edge (combinational)
//   illegal_op               one-cycle pulse after an undefined opcode
//   stall_count              saturating stall + flush cycle count
// ---------------------------------------------------------------------------
module pipelined_control_unit #(
    parameter int unsigned ALUOP_W     = 3,
    parameter int unsigned STALL_CNT_W = 16,
    parameter bit          HAZARD_EN   = 1'b1,
    parameter logic [5:0]  JR_FUNCT    = 6'h08
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_valid,
    input  logic [5:0]             id_opcode,
    input  logic [5:0]             id_funct,
    input  logic [4:0]             id_rs,
    input  logic [4:0]             id_rt,
    input  logic                   ex_zero,
    output logic                   ex_reg_dst,
    output logic                   ex_beq,
    output logic                   ex_bne,
    output logic                   ex_valid,
    output logic [1:0]             ex_alu_src,
    output logic [ALUOP_W-1:0]     ex_alu_op,
    output logic                   mem_read,
    output logic                   mem_write,
    output logic                   wb_mem_to_reg,
    output logic                   wb_reg_write,
    output logic                   id_jump,
    output logic                   id_jr,
    output logic                   branch_taken,
    output logic                   pc_write,
    output logic                   if_id_write,
    output logic                   if_id_flush,
    output logic                   illegal_op,
    output logic [STALL_CNT_W-1:0] stall_count
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(3'b000);
    localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(3'b001);
    localparam logic [ALUOP_W-1:0] ALU_RF  = ALUOP_W'(3'b010);
    localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(3'b011);
    localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(3'b100);
    localparam logic [ALUOP_W-1:0] ALU_XOR = ALUOP_W'(3'b101);
    localparam logic [ALUOP_W-1:0] ALU_SLT = ALUOP_W'(3'b110);

    localparam logic [1:0] SRC_REG  = 2'b00;
    localparam logic [1:0] SRC_SEXT = 2'b01;
    localparam logic [1:0] SRC_ZEXT = 2'b10;

    // Control bundle held in the ID/EX register
    typedef struct packed {
        logic               valid;
        logic               reg_dst;
        logic               beq;
        logic               bne;
        logic [1:0]         alu_src;
        logic [ALUOP_W-1:0] alu_op;
        logic               mem_read;
        logic               mem_write;
        logic               mem_to_reg;
        logic               reg_write;
        logic [4:0]         rt;
    } idex_t;

    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
        logic reg_write;
    } exmem_t;

    typedef struct packed {
        logic mem_to_reg;
        logic reg_write;
    } memwb_t;

    idex_t                  dec_c;
    logic                   dec_jump_c;
    logic                   dec_jr_c;
    logic                   dec_illegal_c;
    logic                   uses_rt_c;
    logic                   load_use_c;
    logic                   stall_c;
    logic                   bubble_c;
    logic                   taken_c;

    idex_t                  idex_d, idex_q;
    exmem_t                 exmem_d, exmem_q;
    memwb_t                 memwb_d, memwb_q;
    logic                   illegal_d, illegal_q;
    logic [STALL_CNT_W-1:0] stall_cnt_d, stall_cnt_q;

    // Opcode decode; an invalid ID slot yields the all-zero NOP bundle
    always_comb begin
        dec_c         = '0;
        dec_jump_c    = 1'b0;
        dec_jr_c      = 1'b0;
        dec_illegal_c = 1'b0;
        if (id_valid) begin
            dec_c.valid = 1'b1;
            dec_c.rt    = id_rt;
            unique case (id_opcode)
                OP_RTYPE: begin
                    if (id_funct == JR_FUNCT) begin
                        dec_jr_c = 1'b1;
                    end else begin
                        dec_c.reg_dst   = 1'b1;
                        dec_c.alu_op    = ALU_RF;
                        dec_c.reg_write = 1'b1;
                    end
                end
                OP_J: dec_jump_c = 1'b1;
                OP_BEQ: begin
                    dec_c.beq    = 1'b1;
                    dec_c.alu_op = ALU_SUB;
                end
                OP_BNE: begin
                    dec_c.bne    = 1'b1;
                    dec_c.alu_op = ALU_SUB;
                end
                OP_LW: begin
                    dec_c.mem_read   = 1'b1;
                    dec_c.mem_to_reg = 1'b1;
                    dec_c.reg_write  = 1'b1;
                    dec_c.alu_src    = SRC_SEXT;
                    dec_c.alu_op     = ALU_ADD;
                end
                OP_SW: begin
                    dec_c.mem_write = 1'b1;
                    dec_c.alu_src   = SRC_SEXT;
                    dec_c.alu_op    = ALU_ADD;
                end
                OP_ADDI: begin
                    dec_c.alu_src   = SRC_SEXT;
                    dec_c.alu_op    = ALU_ADD;
                    dec_c.reg_write = 1'b1;
                end
                OP_SLTI: begin
                    dec_c.alu_src   = SRC_SEXT;
                    dec_c.alu_op    = ALU_SLT;
                    dec_c.reg_write = 1'b1;
                end
                OP_ANDI: begin
                    dec_c.alu_src   = SRC_ZEXT;
                    dec_c.alu_op    = ALU_AND;
                    dec_c.reg_write = 1'b1;
                end
                OP_ORI: begin
                    dec_c.alu_src   = SRC_ZEXT;
                    dec_c.alu_op    = ALU_OR;
                    dec_c.reg_write = 1'b1;
                end
                OP_XORI: begin
                    dec_c.alu_src   = SRC_ZEXT;
                    dec_c.alu_op    = ALU_XOR;
                    dec_c.reg_write = 1'b1;
                end
                default: begin
                    // Undefined opcode travels down the pipe as a NOP
                    dec_c         = '0;
                    dec_illegal_c = 1'b1;
                end
            endcase
        end
    end

    assign uses_rt_c = (id_opcode == OP_RTYPE) || (id_opcode == OP_BEQ) ||
                       (id_opcode == OP_BNE)   || (id_opcode == OP_SW);

    // Hazard and branch resolution; a taken branch outranks a load-use stall
    always_comb begin
        taken_c    = idex_q.valid &
                     ((idex_q.beq & ex_zero) | (idex_q.bne & ~ex_zero));
        load_use_c = HAZARD_EN && idex_q.valid && idex_q.mem_read &&
                     (idex_q.rt != 5'd0) && id_valid &&
                     ((idex_q.rt == id_rs) || (uses_rt_c && (idex_q.rt == id_rt)));
        stall_c    = load_use_c & ~taken_c;
        bubble_c   = stall_c | taken_c;
    end

    assign id_jump      = dec_jump_c;
    assign id_jr        = dec_jr_c;
    assign branch_taken = taken_c;
    assign pc_write     = ~stall_c;
    assign if_id_write  = ~stall_c;
    // A stalled jump stays in ID, so its flush waits until it is released
    assign if_id_flush  = taken_c | ((dec_jump_c | dec_jr_c) & ~stall_c);

    // Next-state for the control pipeline and monitor counter
    always_comb begin
        idex_d      = bubble_c ? idex_t'('0) : dec_c;
        exmem_d     = '{mem_read:   idex_q.mem_read,
                        mem_write:  idex_q.mem_write,
                        mem_to_reg: idex_q.mem_to_reg,
                        reg_write:  idex_q.reg_write};
        memwb_d     = '{mem_to_reg: exmem_q.mem_to_reg,
                        reg_write:  exmem_q.reg_write};
        // A stalled illegal op is decoded again next cycle; report it once
        illegal_d   = dec_illegal_c & ~bubble_c;
        stall_cnt_d = stall_cnt_q;
        if (bubble_c && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    // Control registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idex_q      <= '0;
            exmem_q     <= '0;
            memwb_q     <= '0;
            illegal_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            idex_q      <= idex_d;
            exmem_q     <= exmem_d;
            memwb_q     <= memwb_d;
            illegal_q   <= illegal_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign ex_valid      = idex_q.valid;
    assign ex_reg_dst    = idex_q.reg_dst;
    assign ex_beq        = idex_q.beq;
    assign ex_bne        = idex_q.bne;
    assign ex_alu_src    = idex_q.alu_src;
    assign ex_alu_op     = idex_q.alu_op;
    assign mem_read      = exmem_q.mem_read;
    assign mem_write     = exmem_q.mem_write;
    assign wb_mem_to_reg = memwb_q.mem_to_reg;
    assign wb_reg_write  = memwb_q.reg_write;
    assign illegal_op    = illegal_q;
    assign stall_count   = stall_cnt_q;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// ---------------------------------------------------------------------------
// tb_pipelined_control_unit
// Directed bench. u_main uses the default parameters. u_sat uses a 4-bit
// counter so saturation is reachable in a short run. u_nohz has hazard
// detection disabled. All three instances share the same inputs.
// ---------------------------------------------------------------------------
module tb_pipelined_control_unit;

    logic clk = 1'b0;
    logic rst;
    logic id_valid;
    logic [5:0] id_opcode, id_funct;
    logic [4:0] id_rs, id_rt;
    logic ex_zero;

    always #5 clk = ~clk;

    // main instance outputs
    logic m_reg_dst, m_beq, m_bne, m_valid, m_mem_read, m_mem_write;
    logic m_mem_to_reg, m_reg_write, m_jump, m_jr, m_taken;
    logic m_pc_write, m_if_id_write, m_flush, m_illegal;
    logic [1:0] m_alu_src;
    logic [2:0] m_alu_op;
    logic [15:0] m_cnt;

    // saturation instance outputs
    logic s_reg_dst, s_beq, s_bne, s_valid, s_mem_read, s_mem_write;
    logic s_mem_to_reg, s_reg_write, s_jump, s_jr, s_taken;
    logic s_pc_write, s_if_id_write, s_flush, s_illegal;
    logic [1:0] s_alu_src;
    logic [2:0] s_alu_op;
    logic [3:0] s_cnt;

    // hazard-disabled instance outputs
    logic n_reg_dst, n_beq, n_bne, n_valid, n_mem_read, n_mem_write;
    logic n_mem_to_reg, n_reg_write, n_jump, n_jr, n_taken;
    logic n_pc_write, n_if_id_write, n_flush, n_illegal;
    logic [1:0] n_alu_src;
    logic [2:0] n_alu_op;
    logic [15:0] n_cnt;

    pipelined_control_unit u_main (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_funct(id_funct), .id_rs(id_rs), .id_rt(id_rt), .ex_zero(ex_zero),
        .ex_reg_dst(m_reg_dst), .ex_beq(m_beq), .ex_bne(m_bne), .ex_valid(m_valid),
        .ex_alu_src(m_alu_src), .ex_alu_op(m_alu_op), .mem_read(m_mem_read),
        .mem_write(m_mem_write), .wb_mem_to_reg(m_mem_to_reg), .wb_reg_write(m_reg_write),
        .id_jump(m_jump), .id_jr(m_jr), .branch_taken(m_taken), .pc_write(m_pc_write),
        .if_id_write(m_if_id_write), .if_id_flush(m_flush), .illegal_op(m_illegal),
        .stall_count(m_cnt)
    );

    pipelined_control_unit #(.STALL_CNT_W(4)) u_sat (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_funct(id_funct), .id_rs(id_rs), .id_rt(id_rt), .ex_zero(ex_zero),
        .ex_reg_dst(s_reg_dst), .ex_beq(s_beq), .ex_bne(s_bne), .ex_valid(s_valid),
        .ex_alu_src(s_alu_src), .ex_alu_op(s_alu_op), .mem_read(s_mem_read),
        .mem_write(s_mem_write), .wb_mem_to_reg(s_mem_to_reg), .wb_reg_write(s_reg_write),
        .id_jump(s_jump), .id_jr(s_jr), .branch_taken(s_taken), .pc_write(s_pc_write),
        .if_id_write(s_if_id_write), .if_id_flush(s_flush), .illegal_op(s_illegal),
        .stall_count(s_cnt)
    );

    pipelined_control_unit #(.HAZARD_EN(1'b0)) u_nohz (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_funct(id_funct), .id_rs(id_rs), .id_rt(id_rt), .ex_zero(ex_zero),
        .ex_reg_dst(n_reg_dst), .ex_beq(n_beq), .ex_bne(n_bne), .ex_valid(n_valid),
        .ex_alu_src(n_alu_src), .ex_alu_op(n_alu_op), .mem_read(n_mem_read),
        .mem_write(n_mem_write), .wb_mem_to_reg(n_mem_to_reg), .wb_reg_write(n_reg_write),
        .id_jump(n_jump), .id_jr(n_jr), .branch_taken(n_taken), .pc_write(n_pc_write),
        .if_id_write(n_if_id_write), .if_id_flush(n_flush), .illegal_op(n_illegal),
        .stall_count(n_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic [5:0] op, input logic [5:0] fn,
                          input logic [4:0] rs, input logic [4:0] rt);
        id_valid  = v;
        id_opcode = op;
        id_funct  = fn;
        id_rs     = rs;
        id_rt     = rt;
    endtask

    // Advance one clock; new inputs are applied 1 time unit after the edge
    task automatic go();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst     = 1'b1;
        ex_zero = 1'b0;
        set_id(1'b0, 6'h00, 6'h00, 5'd0, 5'd0);
        #3;
        check_eq("rst_ex_valid", 32'(m_valid), 32'd0);
        check_eq("rst_wb_reg_write", 32'(m_reg_write), 32'd0);
        check_eq("rst_stall_count", 32'(m_cnt), 32'd0);
        check_eq("rst_illegal", 32'(m_illegal), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // ori: control appears in EX one edge later, WB three edges later
        go();
        set_id(1'b1, 6'h0D, 6'h00, 5'd1, 5'd2);
        settle();
        check_eq("ori_pc_write", 32'(m_pc_write), 32'd1);
        check_eq("ori_flush", 32'(m_flush), 32'd0);
        go();
        set_id(1'b0, 6'h00, 6'h00, 5'd0, 5'd0);
        settle();
        check_eq("ori_ex_alu_src", 32'(m_alu_src), 32'd2);
        check_eq("ori_ex_alu_op", 32'(m_alu_op), 32'd4);
        check_eq("ori_ex_valid", 32'(m_valid), 32'd1);
        check_eq("ori_ex_reg_dst", 32'(m_reg_dst), 32'd0);
        go();
        check_eq("ori_wb_early", 32'(m_reg_write), 32'd0);
        go();
        check_eq("ori_wb_reg_write", 32'(m_reg_write), 32'd1);
        check_eq("ori_wb_mem_to_reg", 32'(m_mem_to_reg), 32'd0);

        // lw $8 then add rs=8: one-cycle stall and bubble
        set_id(1'b1, 6'h23, 6'h00, 5'd0, 5'd8);
        settle();
        check_eq("lw_pc_write", 32'(m_pc_write), 32'd1);
        go();
        set_id(1'b1, 6'h00, 6'h20, 5'd8, 5'd9);
        settle();
        check_eq("lu_pc_write", 32'(m_pc_write), 32'd0);
        check_eq("lu_if_id_write", 32'(m_if_id_write), 32'd0);
        check_eq("lu_flush", 32'(m_flush), 32'd0);
        check_eq("lu_nohz_pc_write", 32'(n_pc_write), 32'd1);
        go();
        settle();
        check_eq("lu_bubble_valid", 32'(m_valid), 32'd0);
        check_eq("lu_release_pc_write", 32'(m_pc_write), 32'd1);
        check_eq("lu_stall_count", 32'(m_cnt), 32'd1);
        check_eq("lu_lw_mem_read", 32'(m_mem_read), 32'd1);
        go();
        set_id(1'b0, 6'h00, 6'h00, 5'd0, 5'd0);
        settle();
        check_eq("lu_add_in_ex_valid", 32'(m_valid), 32'd1);
        check_eq("lu_add_in_ex_reg_dst", 32'(m_reg_dst), 32'd1);
        check_eq("lu_add_in_ex_alu_op", 32'(m_alu_op), 32'd2);
        check_eq("lu_lw_wb_mem_to_reg", 32'(m_mem_to_reg), 32'd1);

        // lw $0 followed by a dependent add never stalls
        go();
        set_id(1'b1, 6'h23, 6'h00, 5'd0, 5'd0);
        go();
        set_id(1'b1, 6'h00, 6'h20, 5'd0, 5'd0);
        settle();
        check_eq("lw_r0_pc_write", 32'(m_pc_write), 32'd1);

        // lw $8 then ori with rt=8: ori does not read rt, so no stall
        go();
        set_id(1'b1, 6'h23, 6'h00, 5'd0, 5'd8);
        go();
        set_id(1'b1, 6'h0D, 6'h00, 5'd5, 5'd8);
        settle();
        check_eq("lw_ori_rt_pc_write", 32'(m_pc_write), 32'd1);

        // beq taken in EX: flush and bubble
        go();
        set_id(1'b1, 6'h04, 6'h00, 5'd1, 5'd2);
        go();
        set_id(1'b1, 6'h00, 6'h20, 5'd1, 5'd2);
        ex_zero = 1'b1;
        settle();
        check_eq("beq_ex_beq", 32'(m_beq), 32'd1);
        check_eq("beq_taken", 32'(m_taken), 32'd1);
        check_eq("beq_flush", 32'(m_flush), 32'd1);
        check_eq("beq_pc_write", 32'(m_pc_write), 32'd1);
        go();
        set_id(1'b0, 6'h00, 6'h00, 5'd0, 5'd0);
        ex_zero = 1'b0;
        settle();
        check_eq("beq_bubble_valid", 32'(m_valid), 32'd0);
        check_eq("beq_stall_count", 32'(m_cnt), 32'd2);

        // bne with zero set: not taken
        set_id(1'b1, 6'h05, 6'h00, 5'd1, 5'd2);
        go();
        set_id(1'b0, 6'h00, 6'h00, 5'd0, 5'd0);
        ex_zero = 1'b1;
        settle();
        check_eq("bne_ex_bne", 32'(m_bne), 32'd1);
        check_eq("bne_taken", 32'(m_taken), 32'd0);
        check_eq("bne_flush", 32'(m_flush), 32'd0);
        go();
        ex_zero = 1'b0;

        // j in ID: one-cycle flush, captured into EX
        set_id(1'b1, 6'h02, 6'h00, 5'd0, 5'd0);
        settle();
        check_eq("j_id_jump", 32'(m_jump), 32'd1);
        check_eq("j_flush", 32'(m_flush), 32'd1);
        check_eq("j_pc_write", 32'(m_pc_write), 32'd1);
        go();
        set_id(1'b0, 6'h00, 6'h00, 5'd0, 5'd0);
        settle();
        check_eq("j_flush_drop", 32'(m_flush), 32'd0);
        check_eq("j_ex_valid", 32'(m_valid), 32'd1);

        // jr in ID: flush, no register write
        set_id(1'b1, 6'h00, 6'h08, 5'd31, 5'd0);
        settle();
        check_eq("jr_id_jr", 32'(m_jr), 32'd1);
        check_eq("jr_flush", 32'(m_flush), 32'd1);
        go();
        set_id(1'b0, 6'h00, 6'h00, 5'd0, 5'd0);
        settle();
        check_eq("jr_ex_reg_dst", 32'(m_reg_dst), 32'd0);
        go();
        go();
        check_eq("jr_wb_reg_write", 32'(m_reg_write), 32'd0);

        // undefined opcode 0x3F: illegal_op pulses once, NOP bundle
        set_id(1'b1, 6'h3F, 6'h00, 5'd0, 5'd0);
        settle();
        check_eq("ill_pre", 32'(m_illegal), 32'd0);
        go();
        set_id(1'b0, 6'h00, 6'h00, 5'd0, 5'd0);
        settle();
        check_eq("ill_pulse", 32'(m_illegal), 32'd1);
        check_eq("ill_ex_valid", 32'(m_valid), 32'd0);
        go();
        check_eq("ill_clear", 32'(m_illegal), 32'd0);

        // 20 more load-use stalls: main counts, 4-bit copy saturates
        for (int i = 0; i < 20; i++) begin
            set_id(1'b1, 6'h23, 6'h00, 5'd0, 5'd8);
            go();
            set_id(1'b1, 6'h00, 6'h20, 5'd8, 5'd9);
            go();
        end
        set_id(1'b0, 6'h00, 6'h00, 5'd0, 5'd0);
        settle();
        check_eq("sat_main_count", 32'(m_cnt), 32'd22);
        check_eq("sat_small_count", 32'(s_cnt), 32'd15);
        check_eq("nohz_count", 32'(n_cnt), 32'd1);
        go();
        check_eq("sat_small_hold", 32'(s_cnt), 32'd15);

        // async reset with lw in EX clears everything immediately
        set_id(1'b1, 6'h23, 6'h00, 5'd0, 5'd8);
        go();
        set_id(1'b0, 6'h00, 6'h00, 5'd0, 5'd0);
        settle();
        check_eq("mid_lw_in_ex", 32'(m_valid), 32'd1);
        rst = 1'b1;
        settle();
        check_eq("mid_rst_ex_valid", 32'(m_valid), 32'd0);
        check_eq("mid_rst_count", 32'(m_cnt), 32'd0);
        check_eq("mid_rst_wb", 32'(m_reg_write), 32'd0);
        check_eq("mid_rst_mem_read", 32'(m_mem_read), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        go();
        check_eq("post_rst_pc_write", 32'(m_pc_write), 32'd1);
        check_eq("post_rst_count", 32'(m_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipelined_control_unit.md
Name: pipelined_control_unit

Overview:
Parametrised successor to the single-cycle opcode decoder for the 5-stage MIPS pipeline. Decodes the ID-stage instruction and carries the control bundle through the ID/EX, EX/MEM and MEM/WB control registers. Detects load-use hazards and resolves branches in EX, with stall, bubble and flush control. Drives the PC/IF-ID enables and keeps a saturating stall counter for performance monitoring.

Parameters:
ALUOP_W, 3, width of ALU operation code
STALL_CNT_W, 16, width of saturating stall/flush counter
HAZARD_EN, 1, 1 = load-use detection active; 0 = never stall (bench/forwarding builds)
JR_FUNCT, 6'h08, funct value decoded as jr under opcode 0

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
id_valid  in  1  ID stage holds a real instruction
id_opcode  in  6  instr[31:26]
id_funct  in  6  instr[5:0]
id_rs  in  5  instr[25:21]
id_rt  in  5  instr[20:16]
ex_zero  in  1  ALU zero flag of the instruction in EX
ex_reg_dst, ex_beq, ex_bne, ex_valid  out  1 each  ID/EX control
ex_alu_src  out  2  00 reg, 01 sign-ext, 10 zero-ext
ex_alu_op  out  ALUOP_W  000 add, 001 sub, 010 R-funct, 011 and, 100 or, 101 xor, 110 slt
mem_read, mem_write  out  1 each  EX/MEM control
wb_mem_to_reg, wb_reg_write  out  1 each  MEM/WB control
id_jump, id_jr  out  1 each  combinational, current ID instruction is j / jr
branch_taken  out  1  combinational: ex_valid & ((ex_beq & ex_zero) | (ex_bne & ~ex_zero))
pc_write, if_id_write  out  1 each  0 = hold PC / IF-ID
if_id_flush  out  1  zero the IF/ID register next edge
illegal_op  out  1  registered, one-cycle pulse for an undefined opcode
stall_count  out  STALL_CNT_W  saturating count of stall and flush cycles

Behaviour:
- Reset (async): all ID/EX, EX/MEM and MEM/WB control regs = 0, so every ex_/mem_/wb_ output, illegal_op and stall_count are 0. Reset mid-stream discards in-flight control immediately.
- Decode (combinational, gated by id_valid; invalid gives the NOP bundle of all zeros):
  - R (0x00): reg_dst 1, alu_op 010, reg_write 1.
  - jr (0x00 with funct JR_FUNCT): id_jr 1, reg_write 0.
  - beq 0x04 / bne 0x05: beq or bne set (distinct), alu_op 001, src 00.
  - lw 0x23: mem_read 1, mem_to_reg 1, reg_write 1, src 01, op 000.
  - sw 0x2B: mem_write 1, src 01, op 000.
  - addi 0x08: src 01, op 000, reg_write 1.
  - slti 0x0A: src 01, op 110, reg_write 1.
  - andi 0x0C, ori 0x0D, xori 0x0E: src 10, op 011/100/101, reg_write 1.
  - j 0x02: id_jump 1.
  - Any other opcode: NOP bundle; illegal_op pulses the next cycle.
  - ALU-result instructions have mem_to_reg 0.
- uses_rt = R-type, beq, bne, sw.
- Load-use stall (HAZARD_EN=1): stall = ex_valid & mem_read_idex & rt_idex!=0 & id_valid & (rt_idex==id_rs | (uses_rt & rt_idex==id_rt)). On stall: pc_write=0, if_id_write=0, and a bubble (all zeros, ex_valid 0) enters ID/EX. Exactly 1 cycle per lw.
- Branch (resolved in EX): when branch_taken, if_id_flush=1 and a bubble enters ID/EX (two wrong-path instructions killed); pc_write=1.
- Jump (id_jump or id_jr with id_valid): if_id_flush=1 for one cycle; ID/EX captures the jump normally with no write effects.
- Priority: branch_taken > stall > jump. A stall coincident with a taken branch is suppressed.
- EX/MEM and MEM/WB shift every cycle unconditionally; latency ID→WB control = 3 edges.
- stall_count increments by 1 on each cycle with stall or branch_taken and saturates at all-ones.

Test Plan:
- Reset asserted mid-stream with lw in EX → all outputs 0 within the same cycle; after release, pc_write=1 and stall_count=0.
- lw $t0 (rt=8) followed by add with rs=8 → one cycle pc_write=0, if_id_write=0, ex_valid=0 bubble; add reaches EX the next cycle; stall_count=1.
- lw rt=0, then a dependent add → no stall. Also HAZARD_EN=0 with a dependent add → no stall.
- beq in EX with ex_zero=1 → branch_taken=1, if_id_flush=1, ID/EX bubble. bne with ex_zero=1 → not taken, no flush.
- j (0x02) in ID → id_jump=1, if_id_flush=1 for 1 cycle, pc_write=1. Opcode 0x3F → illegal_op pulses 1 cycle, NOP bundle.
- ori 0x0D → ex_alu_src=10, ex_alu_op=100 one edge later; wb_reg_write=1 three edges after decode. Force 2^16 stalls → stall_count holds 0xFFFF.
